// File: rtl/bus_splitter_pkg.sv
// bus_splitter_pkg: shared encodings for the CPU-side bus splitter.
// Size codes, FSM states, beat-count lookup and alignment helper.
package bus_splitter_pkg;

  typedef enum logic [1:0] {
    SIZ_BYTE  = 2'b00,
    SIZ_HALF  = 2'b01,
    SIZ_WORD  = 2'b10,
    SIZ_DWORD = 2'b11
  } siz_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_BEAT = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam logic [2:0] NB_SINGLE = 3'd1;
  localparam logic [2:0] NB_WORD   = 3'd2;
  localparam logic [2:0] NB_DWORD  = 3'd4;

  function automatic logic [2:0] nbeats(
    input logic [1:0] siz
  );
    logic [2:0] n;
    n = NB_SINGLE;
    unique case (siz)
      SIZ_WORD:  n = NB_WORD;
      SIZ_DWORD: n = NB_DWORD;
      default:   n = NB_SINGLE;
    endcase
    return n;
  endfunction

  function automatic logic misaligned(
    input logic [1:0] siz,
    input logic [2:0] adr
  );
    logic m;
    m = 1'b0;
    unique case (siz)
      SIZ_HALF:  m = adr[0];
      SIZ_WORD:  m = |adr[1:0];
      SIZ_DWORD: m = |adr;
      default:   m = 1'b0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/bus_splitter_watchdog.sv
// bus_ack_watchdog: counts BEAT cycles without a downstream ack.
// Ports: clk_i, reset_i, i_clr (launch/ack), i_run (in BEAT), o_expire.
module bus_ack_watchdog #(
  parameter int W = 8
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic i_clr,
  input  logic i_run,
  output logic o_expire
);

  logic [W-1:0] r_cnt;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_run) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = &r_cnt;

endmodule

// File: rtl/bus_splitter.sv
// bus_splitter: splits 8..64-bit CPU transfers into 8/16-bit beats.
// Ports: m_* master side, s_* narrower side; optional BUS_SPLITTER_WATCHDOG_EN.
module bus_splitter
  import bus_splitter_pkg::*;
#(
  parameter int TIMEOUT_W = 8
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [63:0] m_adr_i,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  input  logic        m_we_i,
  input  logic [1:0]  m_siz_i,
  input  logic        m_signed_i,
  input  logic [63:0] m_dat_i,
  output logic        m_ack_o,
  output logic [63:0] m_dat_o,
  output logic        m_err_align_o,
  output logic        m_err_bus_o,
  output logic [63:0] s_adr_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  output logic        s_we_o,
  output logic [1:0]  s_siz_o,
  output logic        s_signed_o,
  output logic [63:0] s_dat_o,
  input  logic        s_ack_i,
  input  logic [63:0] s_dat_i
);

  state_e      r_state, w_state_nxt;
  logic [63:0] r_dat, r_acc, w_acc_nxt, w_rdata;
  logic [1:0]  r_k, r_last, r_siz, w_k_nxt;
  logic        r_signed;
  logic [2:0]  w_nb_m1;
  logic        w_req, w_mis, w_launch, w_abort;
  logic        w_ack, w_last, w_expire, w_timeout;

  logic        r_m_ack, r_m_err_bus;
  logic [63:0] r_m_dat, r_s_adr, r_s_dat;
  logic        r_s_cyc, r_s_we, r_s_signed;
  logic [1:0]  r_s_siz;

  assign w_req    = m_cyc_i & m_stb_i;
  assign w_mis    = misaligned(m_siz_i, m_adr_i[2:0]);
  assign w_launch = w_req & (r_state == ST_IDLE) & ~w_mis;
  assign w_abort  = (r_state == ST_BEAT) & ~m_cyc_i;
  assign w_ack    = (r_state == ST_BEAT) & m_cyc_i & s_ack_i;
  assign w_last   = w_ack & (r_k == r_last);
  assign w_timeout = (r_state == ST_BEAT) & m_cyc_i
                   & ~s_ack_i & w_expire;
  assign w_nb_m1  = nbeats(m_siz_i) - 3'd1;
  assign w_k_nxt  = r_k + 2'd1;

  assign m_err_align_o = w_req & (r_state == ST_IDLE) & w_mis;

`ifdef BUS_SPLITTER_WATCHDOG_EN
  bus_ack_watchdog #(
    .W(TIMEOUT_W)
  ) u_wd (
    .clk_i    (clk_i),
    .reset_i  (reset_i),
    .i_clr    (w_launch | w_ack),
    .i_run    (r_state == ST_BEAT),
    .o_expire (w_expire)
  );
`else
  logic w_unused_tw;
  assign w_unused_tw = ^TIMEOUT_W;
  assign w_expire    = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) r_state <= ST_IDLE;
    else         r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_launch) w_state_nxt = ST_BEAT;
      ST_BEAT: begin
        if (w_abort | w_timeout) w_state_nxt = ST_IDLE;
        else if (w_last)         w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Slot k of the accumulator including the beat acked this cycle.
  always_comb begin
    w_acc_nxt = r_acc;
    w_acc_nxt[{r_k, 4'b0000} +: 16] = s_dat_i[15:0];
  end

  always_comb begin
    w_rdata = '0;
    if (!r_s_we) begin
      unique case (r_siz)
        SIZ_WORD: w_rdata = {{32{r_signed & w_acc_nxt[31]}},
                             w_acc_nxt[31:0]};
        SIZ_DWORD: w_rdata = w_acc_nxt;
        default:  w_rdata = s_dat_i;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_dat       <= '0;
      r_acc       <= '0;
      r_k         <= '0;
      r_last      <= '0;
      r_siz       <= '0;
      r_signed    <= 1'b0;
      r_m_ack     <= 1'b0;
      r_m_dat     <= '0;
      r_m_err_bus <= 1'b0;
      r_s_adr     <= '0;
      r_s_dat     <= '0;
      r_s_cyc     <= 1'b0;
      r_s_we      <= 1'b0;
      r_s_siz     <= '0;
      r_s_signed  <= 1'b0;
    end else begin
      r_m_ack     <= 1'b0;
      r_m_dat     <= '0;
      r_m_err_bus <= 1'b0;
      if (w_launch) begin
        r_dat      <= m_dat_i;
        r_acc      <= '0;
        r_k        <= '0;
        r_last     <= w_nb_m1[1:0];
        r_siz      <= m_siz_i;
        r_signed   <= m_signed_i;
        r_s_cyc    <= 1'b1;
        r_s_we     <= m_we_i;
        r_s_siz    <= (m_siz_i == SIZ_BYTE) ? SIZ_BYTE : SIZ_HALF;
        // Split beats are raw halves; extension happens here.
        r_s_signed <= m_signed_i & ~m_siz_i[1];
        r_s_adr    <= m_adr_i;
        r_s_dat    <= {48'b0, m_dat_i[15:0]};
      end else if (w_abort | w_timeout | w_last) begin
        r_s_cyc     <= 1'b0;
        r_s_we      <= 1'b0;
        r_s_siz     <= '0;
        r_s_signed  <= 1'b0;
        r_s_adr     <= '0;
        r_s_dat     <= '0;
        r_m_err_bus <= w_timeout;
        if (w_last) begin
          r_m_ack <= 1'b1;
          r_m_dat <= w_rdata;
        end
      end else if (w_ack) begin
        r_acc   <= w_acc_nxt;
        r_k     <= w_k_nxt;
        r_s_adr <= r_s_adr + 64'd2;
        r_s_dat <= {48'b0, r_dat[{w_k_nxt, 4'b0000} +: 16]};
      end
    end
  end

  assign m_ack_o     = r_m_ack;
  assign m_dat_o     = r_m_dat;
  assign m_err_bus_o = r_m_err_bus;
  assign s_adr_o     = r_s_adr;
  assign s_cyc_o     = r_s_cyc;
  assign s_stb_o     = r_s_cyc;
  assign s_we_o      = r_s_we;
  assign s_siz_o     = r_s_siz;
  assign s_signed_o  = r_s_signed;
  assign s_dat_o     = r_s_dat;

endmodule

// File: tb/tb_bus_splitter.sv
// tb_bus_splitter: directed + random transfers against a beat-level model.
// Plays the narrower as slave; checks beats, read assembly, latency.
module tb_bus_splitter;

  localparam int TW = 4;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [63:0] m_adr_i, m_dat_i, s_dat_i;
  logic        m_cyc_i, m_stb_i, m_we_i, m_signed_i, s_ack_i;
  logic [1:0]  m_siz_i;
  logic        m_ack_o, m_err_align_o, m_err_bus_o;
  logic [63:0] m_dat_o, s_adr_o, s_dat_o;
  logic        s_cyc_o, s_stb_o, s_we_o, s_signed_o;
  logic [1:0]  s_siz_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_splitter #(.TIMEOUT_W(TW)) dut (
    .clk_i(clk), .reset_i(reset_i),
    .m_adr_i(m_adr_i), .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i),
    .m_we_i(m_we_i), .m_siz_i(m_siz_i), .m_signed_i(m_signed_i),
    .m_dat_i(m_dat_i), .m_ack_o(m_ack_o), .m_dat_o(m_dat_o),
    .m_err_align_o(m_err_align_o), .m_err_bus_o(m_err_bus_o),
    .s_adr_o(s_adr_o), .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s_we_o(s_we_o), .s_siz_o(s_siz_o), .s_signed_o(s_signed_o),
    .s_dat_o(s_dat_o), .s_ack_i(s_ack_i), .s_dat_i(s_dat_i)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Narrower behaviour for single-beat reads.
  function automatic logic [63:0] narrow(input logic [1:0] siz,
                                         input logic sgn,
                                         input logic [63:0] raw);
    if (siz == 2'b00) return {{56{sgn & raw[7]}}, raw[7:0]};
    return {{48{sgn & raw[15]}}, raw[15:0]};
  endfunction

  // Expected master read data: rd holds the single-beat value or
  // the halfwords returned by successive beats, lowest first.
  function automatic logic [63:0] exp_read(input logic [1:0] siz,
                                           input logic sgn,
                                           input logic [63:0] rd);
    longint w;
    if (siz == 2'b11) return rd;
    if (siz == 2'b10) begin
      w = sgn ? longint'(int'(rd[31:0])) : longint'(rd[31:0]);
      return 64'(w);
    end
    return rd;
  endfunction

  task automatic idle_inputs();
    m_cyc_i = 0; m_stb_i = 0; m_we_i = 0; m_siz_i = 0;
    m_signed_i = 0; m_adr_i = 0; m_dat_i = 0;
    s_ack_i = 0; s_dat_i = 0;
  endtask

  task automatic xfer(input string tag, input logic [63:0] adr,
                      input logic [1:0] siz, input logic we,
                      input logic sgn, input logic [63:0] wdat,
                      input logic [63:0] rd, input int wait_pct);
    int nb, i, cyc, waits;
    bit done;
    nb = (siz == 3) ? 4 : (siz == 2) ? 2 : 1;
    i = 0; cyc = 0; waits = 0; done = 0;
    @(posedge clk); #1;
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = adr; m_siz_i = siz;
    m_we_i = we; m_signed_i = sgn; m_dat_i = wdat;
    #1 chk({tag, ".align"}, 64'(m_err_align_o), 0);
    for (int t = 0; t < 60 && !done; t++) begin
      @(posedge clk); #1;
      cyc++;
      if (m_ack_o) begin
        done = 1;
        chk({tag, ".lat"}, 64'(cyc + 1), 64'(nb + 2 + waits));
        chk({tag, ".nbeats"}, 64'(i), 64'(nb));
        chk({tag, ".rdata"}, m_dat_o,
            we ? 64'd0 : exp_read(siz, sgn, rd));
        chk({tag, ".errbus"}, 64'(m_err_bus_o), 0);
        idle_inputs();
      end else if (s_stb_o) begin
        if (i < nb) begin
          chk({tag, ".cyc"}, 64'(s_cyc_o), 1);
          chk({tag, ".adr"}, s_adr_o, adr + 64'(2 * i));
          chk({tag, ".siz"}, 64'(s_siz_o), (siz == 0) ? 0 : 1);
          chk({tag, ".sgn"}, 64'(s_signed_o), (siz < 2) ? 64'(sgn) : 0);
          chk({tag, ".we"}, 64'(s_we_o), 64'(we));
          if (we && siz == 0)
            chk({tag, ".wdat"}, {56'b0, s_dat_o[7:0]},
                {56'b0, wdat[7:0]});
          else if (we)
            chk({tag, ".wdat"}, s_dat_o,
                (wdat >> (16 * i)) & 64'hFFFF);
        end else begin
          chk({tag, ".extra_beat"}, 64'(i), 64'(nb - 1));
        end
        if ($urandom_range(0, 99) >= wait_pct) begin
          s_ack_i = 1;
          if (nb == 1) s_dat_i = rd;
          else s_dat_i = {16'($urandom), 16'($urandom),
                          16'($urandom), rd[16 * i +: 16]};
          i++;
        end else begin
          s_ack_i = 0;
          waits++;
        end
      end else begin
        s_ack_i = 0;
      end
    end
    if (!done) begin
      chk({tag, ".ack_timeout"}, 0, 1);
      idle_inputs();
    end
    @(posedge clk); #1;
    chk({tag, ".ack_pulse"}, 64'(m_ack_o), 0);
    chk({tag, ".cyc_after"}, 64'(s_cyc_o), 0);
  endtask

  task automatic mis(input string tag, input logic [63:0] adr,
                     input logic [1:0] siz);
    bit bad;
    bad = 0;
    @(posedge clk); #1;
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = adr; m_siz_i = siz;
    m_we_i = 0; m_dat_i = 0;
    #1 chk({tag, ".err"}, 64'(m_err_align_o), 1);
    for (int t = 0; t < 4; t++) begin
      @(posedge clk); #1;
      bad |= s_cyc_o | m_ack_o | ~m_err_align_o;
    end
    chk({tag, ".quiet"}, 64'(bad), 0);
    idle_inputs();
    #1 chk({tag, ".err_clr"}, 64'(m_err_align_o), 0);
  endtask

  initial begin
    logic [63:0] adr, dat, raw, rd, mask;
    logic [1:0]  siz;
    logic        we, sgn;
    bit          seen;
    int          lat;

    idle_inputs();
    reset_i = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.outs", {m_ack_o, m_err_bus_o, s_cyc_o, s_stb_o,
                     s_we_o, s_siz_o, s_signed_o}, 0);
    chk("rst.mdat", m_dat_o, 0);
    chk("rst.sadr", s_adr_o, 0);
    chk("rst.sdat", s_dat_o, 0);
    reset_i = 0;

    s_ack_i = 1; s_dat_i = 64'h1234;
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      seen |= m_ack_o | s_cyc_o;
    end
    chk("idle_ack.ignored", 64'(seen), 0);
    idle_inputs();

    xfer("byte_rd", 64'h1003, 2'b00, 0, 1, 0,
         64'hFFFF_FFFF_FFFF_FF80, 0);
    xfer("dword_wr", 64'h2000, 2'b11, 1, 0,
         64'h1122_3344_5566_7788, 0, 0);
    xfer("word_rd_s", 64'h3004, 2'b10, 0, 1, 0,
         64'h0000_0000_FFFE_8001, 0);
    xfer("word_rd_u", 64'h3004, 2'b10, 0, 0, 0,
         64'h0000_0000_FFFE_8001, 0);
    xfer("byte_wr", 64'h5001, 2'b00, 1, 0, 64'h0000_0000_0000_ABCD, 0, 0);

    mis("mis_word", 64'h3002, 2'b10);
    mis("mis_dword", 64'h4004, 2'b11);
    mis("mis_half", 64'h5001, 2'b01);

    // Abort after first beat of a dword read.
    @(posedge clk); #1;
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 64'h7000; m_siz_i = 2'b11;
    m_we_i = 0; m_signed_i = 0;
    @(posedge clk); #1;
    chk("abort.beat0", s_adr_o, 64'h7000);
    s_ack_i = 1; s_dat_i = 64'h5555;
    @(posedge clk); #1;
    chk("abort.beat1", s_adr_o, 64'h7002);
    m_cyc_i = 0; m_stb_i = 0; s_ack_i = 0;
    @(posedge clk); #1;
    chk("abort.cyc", {62'b0, s_cyc_o, s_stb_o}, 0);
    seen = 0;
    repeat (3) begin
      @(posedge clk); #1;
      seen |= m_ack_o | s_cyc_o;
    end
    chk("abort.noack", 64'(seen), 0);
    idle_inputs();
    xfer("after_abort", 64'h7100, 2'b10, 0, 0, 0, 64'h0000_0000_0003_0004, 0);

    // Reset in BEAT, request still held.
    @(posedge clk); #1;
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 64'h6000; m_siz_i = 2'b11;
    m_we_i = 1; m_dat_i = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk); #1;
    chk("rstbeat.cyc", 64'(s_cyc_o), 1);
    s_ack_i = 1;
    @(posedge clk); #1;
    chk("rstbeat.beat1", s_adr_o, 64'h6002);
    reset_i = 1; s_ack_i = 0;
    @(posedge clk); #1;
    chk("rstbeat.outs", {m_ack_o, m_err_bus_o, s_cyc_o, s_stb_o,
                         s_we_o, s_siz_o, s_signed_o}, 0);
    chk("rstbeat.sadr", s_adr_o, 0);
    chk("rstbeat.sdat", s_dat_o, 0);
    chk("rstbeat.mdat", m_dat_o, 0);
    reset_i = 0;
    idle_inputs();

    for (int n = 0; n < 40; n++) begin
      siz  = 2'($urandom_range(0, 3));
      we   = 1'($urandom_range(0, 1));
      sgn  = 1'($urandom_range(0, 1));
      mask = (siz == 3) ? 64'd7 : (siz == 2) ? 64'd3 :
             (siz == 1) ? 64'd1 : 64'd0;
      adr  = {$urandom, $urandom} & ~mask;
      dat  = {$urandom, $urandom};
      raw  = {$urandom, $urandom};
      rd   = (siz >= 2) ? raw : narrow(siz, sgn, raw);
      xfer($sformatf("rand%0d", n), adr, siz, we, sgn, dat, rd, 30);
    end

    // Downstream never acks.
    @(posedge clk); #1;
    m_cyc_i = 1; m_stb_i = 1; m_adr_i = 64'h8000; m_siz_i = 2'b01;
    m_we_i = 0;
`ifdef BUS_SPLITTER_WATCHDOG_EN
    lat = 0; seen = 0;
    for (int t = 1; t <= 40 && lat == 0; t++) begin
      @(posedge clk); #1;
      seen |= m_ack_o;
      if (m_err_bus_o) begin
        lat = t;
        chk("wd.cyc_drop", 64'(s_cyc_o), 0);
      end
    end
    chk("wd.lat_ok", 64'(lat >= (1 << TW) - 1 && lat <= (1 << TW) + 1), 1);
    chk("wd.noack", 64'(seen), 0);
    idle_inputs();
    @(posedge clk); #1;
    chk("wd.pulse", 64'(m_err_bus_o), 0);
`else
    seen = 0; lat = 0;
    repeat (40) begin
      @(posedge clk); #1;
      seen |= m_err_bus_o | m_ack_o;
    end
    chk("nowd.err", 64'(seen), 0);
    chk("nowd.wait", 64'(s_cyc_o), 1);
    idle_inputs();
    @(posedge clk); #1;
    chk("nowd.abort", 64'(s_cyc_o), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/bus_splitter.md
Name: bus_splitter

Overview:
- Sits directly upstream of the 64-to-16-bit bus narrower.
- Accepts full-width CPU transfers of 8, 16, 32 or 64 bits and issues a sequence of 8/16-bit transfers to the narrower:
  - 32-bit transfers become two halfword beats.
  - 64-bit transfers become four halfword beats.
- Assembles read data and applies sign/zero extension.
- Returns a single acknowledge to the master.

Parameters:
- TIMEOUT_W, 8, width of the watchdog counter. Used only when the optional feature is compiled in.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- m_adr_i  in  64  master byte address
- m_cyc_i  in  1  master cycle valid
- m_stb_i  in  1  master strobe
- m_we_i  in  1  master write
- m_siz_i  in  2  size: 00=byte, 01=half, 10=word, 11=dword
- m_signed_i  in  1  sign-extend read data
- m_dat_i  in  64  master write data
- m_ack_o  out  1  transfer complete, one-cycle pulse
- m_dat_o  out  64  assembled read data, valid while m_ack_o is high
- m_err_align_o  out  1  misaligned request, combinational
- m_err_bus_o  out  1  downstream timeout, one-cycle pulse
- s_adr_o  out  64  beat address
- s_cyc_o  out  1  downstream cycle
- s_stb_o  out  1  downstream strobe
- s_we_o  out  1  downstream write
- s_siz_o  out  2  beat size, always 00 or 01
- s_signed_o  out  1  beat signedness
- s_dat_o  out  64  beat write data, low 16 bits meaningful, upper bits zero
- s_ack_i  in  1  downstream acknowledge
- s_dat_i  in  64  downstream read data, already extended by the narrower

Behaviour:
- One clock clk_i; reset_i is synchronous, active-high.
- Reset state: IDLE. All registered outputs 0: m_ack_o, m_dat_o, m_err_bus_o, s_cyc_o, s_stb_o, s_we_o, s_siz_o, s_signed_o, s_adr_o, s_dat_o.

Request and alignment:
- req = m_cyc_i & m_stb_i.
- m_err_align_o = req & IDLE & misaligned, where misaligned means:
  - siz 01 with adr[0] set;
  - siz 10 with adr[1:0] nonzero;
  - siz 11 with adr[2:0] nonzero.
- A misaligned request never starts a downstream cycle and never produces m_ack_o.

FSM states: IDLE, BEAT, DONE.
- IDLE → BEAT on an aligned req. Latch:
  - adr, dat, we, signed, siz;
  - nbeats = 1 for siz 00/01, 2 for siz 10, 4 for siz 11;
  - beat index k = 0.
- BEAT:
  - s_cyc_o = s_stb_o = 1.
  - s_adr_o = adr + 2k.
  - s_dat_o = dat[16k+15:16k], zero-extended to 64 bits.
  - For siz 00: s_siz_o = 00 and the byte is carried in s_dat_o[7:0]. Otherwise s_siz_o = 01.
  - s_signed_o = latched signed for siz 00/01, 0 for split beats.
  - Each s_ack_i stores s_dat_i[15:0] into accumulator slot k and increments k.
  - On ack of the last beat → DONE. s_cyc_o/s_stb_o drop at the next edge.
  - No idle gap between beats: strobe stays high and the address advances on the cycle after each ack.
- DONE:
  - m_ack_o = 1 for exactly one cycle, then → IDLE.
  - Read data for siz 00/01: s_dat_i captured on the ack.
  - Read data for siz 10: accumulator[31:0], sign-extended if signed, else zero-extended.
  - Read data for siz 11: accumulator[63:0].
  - For writes, m_dat_o = 0.
- Latency: nbeats downstream ack cycles plus 2 cycles (launch and DONE). Minimum 3 cycles for a single beat with same-cycle s_ack_i.
- A req still high in the cycle after DONE is treated as a new transfer.

Boundary conditions:
- m_cyc_i deasserted during BEAT: abort; return to IDLE at the next edge; no m_ack_o; accumulator discarded.
- Beats of a write that have already been acknowledged stay committed on abort or reset.
- reset_i during any state: IDLE at the next edge, outputs at reset values.
- s_ack_i while not in BEAT: ignored.
- Byte transfers with any address are legal.

Optional Feature:
- Macro: BUS_SPLITTER_WATCHDOG_EN.
- Compiled in:
  - A TIMEOUT_W-bit counter clears at each beat launch and on each ack, and increments every BEAT cycle without s_ack_i.
  - When the counter reaches its all-ones value: drop s_cyc_o/s_stb_o, pulse m_err_bus_o for one cycle with no m_ack_o, return to IDLE.
- Compiled out: m_err_bus_o is tied 0 and BEAT waits indefinitely.

Decomposition:
- Shared package/header:
  - SIZ_BYTE/SIZ_HALF/SIZ_WORD/SIZ_DWORD encodings;
  - FSM state encodings;
  - beat-count lookup constants.
- One natural sub-module: bus_ack_watchdog (counter, clear, expire), instantiated only under BUS_SPLITTER_WATCHDOG_EN.
- The rest stays flat.

Test Plan:
- Signed byte read, adr=0x1003, s_dat_i=0xFFFF_FFFF_FFFF_FF80 → one beat with s_siz_o=00, s_adr_o=0x1003; m_dat_o=0xFFFF_FFFF_FFFF_FF80; m_ack_o 3 cycles after req.
- Dword write, adr=0x2000, m_dat_i=0x1122_3344_5566_7788 → beats at 0x2000/02/04/06 with s_dat_o=0x7788/0x5566/0x3344/0x1122 (zero-extended), then one m_ack_o.
- Signed word read, adr=0x3004, beats return 0x8001 then 0xFFFE → m_dat_o=0xFFFF_FFFF_FFFE_8001. Unsigned variant → 0x0000_0000_FFFE_8001.
- Misaligned: word at 0x3002, dword at 0x4004, half at 0x5001 → m_err_align_o=1, s_cyc_o stays 0, no m_ack_o.
- Abort/reset: dword read with m_cyc_i dropped after beat 1 → IDLE next cycle, no ack. reset_i asserted in BEAT → all outputs 0 next cycle.
- Watchdog (macro defined, TIMEOUT_W=4): s_ack_i held low → m_err_bus_o pulses after 15 cycles, s_cyc_o drops, no m_ack_o. Macro undefined → m_err_bus_o stays 0.
